// File: rtl/array_west_feeder_pkg.sv
// Shared definitions for the systolic-array west-edge feeder: tile
// instruction encodings, FSM state enum and default geometry.
package array_west_feeder_pkg;

  // 2-bit tile instruction: bit 1 execute, bit 0 kernel load
  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  localparam int ROW_DEF    = 8;
  localparam int COL_DEF    = 8;
  localparam int BW_DEF     = 4;
  localparam int LEN_BW_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_DRAIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/array_west_feeder_skew_line.sv
// Depth-N register chain used to delay one row's {inst, data} by N cycles.
// DEPTH must be at least 1; a zero-delay row is a plain wire in the parent.
module skew_line #(
  parameter int DEPTH = 1,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [DEPTH-1:0][W-1:0] pipe_d, pipe_q;

  // Shift: new word enters slot 0, each slot takes its predecessor
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = d;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end

  // Chain registers, cleared so no stale instruction reaches the array
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pipe_q <= '0;
    else        pipe_q <= pipe_d;
  end

  assign q = pipe_q[DEPTH-1];

endmodule

// File: rtl/array_west_feeder.sv
// West-edge feeder for the MAC-tile array. Accepts row-wide beats over a
// valid/ready stream, issues a kernel-load (col beats) or execute (cmd_len
// beats) burst, skews row r by r cycles and pulses done once the last beat
// has left the bottom row.
// Build option: FEEDER_SKEW_EN builds the per-row skew chains; without it
// every row is driven straight from the row-0 stage (caller pre-skews).
module array_west_feeder
  import array_west_feeder_pkg::*;
#(
  parameter int row    = ROW_DEF,
  parameter int col    = COL_DEF,
  parameter int bw     = BW_DEF,
  parameter int len_bw = LEN_BW_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_op,
  input  logic [len_bw-1:0]   cmd_len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [row*bw-1:0]   in_data,
  output logic [row*bw-1:0]   out_w,
  output logic [row*2-1:0]    inst_w,
  output logic                busy,
  output logic                done
);

  // Cycles spent waiting after the last accept until that beat has left
  // the final stage (bottom row when skewed, row-0 stage otherwise).
`ifdef FEEDER_SKEW_EN
  localparam int DRAIN_CYC = row;
`else
  localparam int DRAIN_CYC = 1;
`endif

  state_e              state_d, state_q;
  logic [len_bw-1:0]   cnt_d, cnt_q;
  logic [1:0]          stage_inst_d, stage_inst_q;
  logic [row*bw-1:0]   stage_data_d, stage_data_q;
  logic                xfer;

  // Handshakes are pure decodes of registered state
  assign cmd_ready = (state_q == S_IDLE);
  assign in_ready  = (state_q == S_LOAD) || (state_q == S_EXEC);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign xfer      = in_valid && in_ready;

  // Next-state, beat/drain counter and row-0 stage contents
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stage_inst_d = INST_IDLE;
    stage_data_d = '0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (!cmd_op) begin
            state_d = S_LOAD;
            cnt_d   = len_bw'(col);
          end else if (cmd_len != '0) begin
            state_d = S_EXEC;
            cnt_d   = cmd_len;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_LOAD, S_EXEC: begin
        if (xfer) begin
          stage_inst_d = (state_q == S_LOAD) ? INST_LOAD : INST_EXEC;
          stage_data_d = in_data;
          if (cnt_q == len_bw'(1)) begin
            state_d = S_DRAIN;
            cnt_d   = len_bw'(DRAIN_CYC - 1);
          end else begin
            cnt_d = cnt_q - len_bw'(1);
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - len_bw'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and row-0 stage registers; reset abandons any burst
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      stage_inst_q <= INST_IDLE;
      stage_data_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stage_inst_q <= stage_inst_d;
      stage_data_q <= stage_data_d;
    end
  end

  // Per-row output: row-0 stage slice, delayed r cycles when skewing
  for (genvar r = 0; r < row; r++) begin : g_lane
    logic [bw+1:0] lane_in, lane_out;
    assign lane_in = {stage_inst_q, stage_data_q[r*bw +: bw]};
`ifdef FEEDER_SKEW_EN
    if (r == 0) begin : g_direct
      assign lane_out = lane_in;
    end else begin : g_skew
      skew_line #(.DEPTH(r), .W(bw+2)) u_skew (
        .clk   (clk),
        .reset (reset),
        .d     (lane_in),
        .q     (lane_out)
      );
    end
`else
    assign lane_out = lane_in;
`endif
    assign inst_w[r*2 +: 2]  = lane_out[bw +: 2];
    assign out_w[r*bw +: bw] = lane_out[bw-1:0];
  end

endmodule

// File: tb/tb_array_west_feeder.sv
// Directed bench for array_west_feeder: per-cycle output log of each burst
// compared against a hand-written table, plus reset and zero-length cases.
module tb_array_west_feeder;
  localparam int ROW = 8, COL = 8, BW = 4, LBW = 16, NC = 24;
`ifdef FEEDER_SKEW_EN
  localparam int R = 1;
`else
  localparam int R = 0;
`endif
  // cycles from last accept edge to the done cycle
  localparam int DLAT = (R != 0) ? ROW : 1;

  logic clk = 1'b0, reset = 1'b0;
  logic cmd_valid = 1'b0, cmd_op = 1'b0, in_valid = 1'b0;
  logic [LBW-1:0]    cmd_len = '0;
  logic [ROW*BW-1:0] in_data = '0;
  logic cmd_ready, in_ready, busy, done;
  logic [ROW*BW-1:0] out_w;
  logic [ROW*2-1:0]  inst_w;

  int n_cmp = 0, n_err = 0;

  typedef struct {
    int         tst;
    int         idx;
    int         rw;
    logic [1:0] inst;
    logic [3:0] dat;
  } vec_t;
  vec_t tab[$];

  logic [ROW*2-1:0]  li [NC];
  logic [ROW*BW-1:0] ld [NC];
  logic lr [NC], ldn [NC], lb [NC], lc [NC];

  always #5 clk = ~clk;

  array_west_feeder #(.row(ROW), .col(COL), .bw(BW), .len_bw(LBW)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_w     (out_w),
    .inst_w    (inst_w),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void add(input int t, input int i, input int r,
                              input logic [1:0] ins, input int d);
    vec_t v;
    v.tst = t; v.idx = i; v.rw = r; v.inst = ins; v.dat = 4'(d);
    tab.push_back(v);
  endfunction

  // beat k: either every lane k+1, or lane r = (r+k) mod 16
  function automatic logic [ROW*BW-1:0] beat(input int k, input bit same);
    logic [ROW*BW-1:0] v;
    v = '0;
    for (int r = 0; r < ROW; r++) v[r*BW +: BW] = same ? BW'(k + 1) : BW'((r + k) & 15);
    return v;
  endfunction

  // Issue a command at edge 0, then log outputs for NC cycles; idx i is
  // the interval after edge i. Beat index advances on each handshake.
  task automatic burst(input logic op, input int len, input logic [NC-1:0] vpat, input bit same);
    int k;
    k = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_len = LBW'(len); in_valid = 1'b0;
    for (int i = 0; i < NC; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      li[i] = inst_w; ld[i] = out_w; lr[i] = in_ready;
      ldn[i] = done; lb[i] = busy; lc[i] = cmd_ready;
      in_valid = vpat[i];
      in_data  = vpat[i] ? beat(k, same) : '0;
      if (vpat[i] && in_ready) k++;
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic check_burst(input int t, input int didx);
    int nd, first;
    nd = 0; first = -1;
    foreach (tab[j]) if (tab[j].tst == t) begin
      chk($sformatf("t%0d inst row%0d idx%0d", t, tab[j].rw, tab[j].idx),
          32'(li[tab[j].idx][tab[j].rw*2 +: 2]), 32'(tab[j].inst));
      chk($sformatf("t%0d data row%0d idx%0d", t, tab[j].rw, tab[j].idx),
          32'(ld[tab[j].idx][tab[j].rw*BW +: BW]), 32'(tab[j].dat));
    end
    for (int i = 0; i < NC; i++) if (ldn[i]) begin
      nd++;
      if (first < 0) first = i;
    end
    chk($sformatf("t%0d done count", t), 32'(nd), 32'd1);
    chk($sformatf("t%0d done idx", t), 32'(first), 32'(didx));
    chk($sformatf("t%0d idle busy", t), 32'(lb[didx+1]), 32'd0);
    chk($sformatf("t%0d idle cmd_ready", t), 32'(lc[didx+1]), 32'd1);
  endtask

  initial begin
    int rws[3];
    rws = '{0, 4, 7};
    // load, continuous valid: beat k accepted at edge k+1
    add(1, 0, 0, 2'b00, 0);
    add(1, 1, 0, 2'b01, 0);
    add(1, 1 + 7*R, 7, 2'b01, 7);
    add(1, 8 + 3*R, 3, 2'b01, 10);
    add(1, 8 + 7*R, 7, 2'b01, 14);
    add(1, 9 + 7*R, 7, 2'b00, 0);
    // execute 4 beats, data 1..4 on every lane
    add(2, 1, 0, 2'b10, 1);
    for (int k = 0; k < 4; k++) add(2, 1 + k + 7*R, 7, 2'b10, k + 1);
    add(2, 5 + 7*R, 7, 2'b00, 0);
    // execute 3 beats with valid 1,0,1,0,1
    for (int j = 0; j < 3; j++) begin
      add(3, 1 + R*rws[j], rws[j], 2'b10, 1);
      add(3, 2 + R*rws[j], rws[j], 2'b00, 0);
      add(3, 3 + R*rws[j], rws[j], 2'b10, 2);
      add(3, 4 + R*rws[j], rws[j], 2'b00, 0);
      add(3, 5 + R*rws[j], rws[j], 2'b10, 3);
    end
    // zero-length execute: nothing enters the array
    add(4, 1, 0, 2'b00, 0);
    add(4, 2, 0, 2'b00, 0);

    // reset state
    repeat (2) @(negedge clk);
    chk("rst out_w", 32'(out_w), 32'd0);
    chk("rst inst_w", 32'(inst_w), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst cmd_ready", 32'(cmd_ready), 32'd1);
    reset = 1'b1;
    @(negedge clk);

    burst(1'b0, 0, '1, 1'b0);
    chk("t1 in_ready idx0", 32'(lr[0]), 32'd1);
    chk("t1 in_ready idx7", 32'(lr[7]), 32'd1);
    chk("t1 in_ready idx8", 32'(lr[8]), 32'd0);
    chk("t1 busy idx0", 32'(lb[0]), 32'd1);
    check_burst(1, 8 + DLAT);

    burst(1'b1, 4, '1, 1'b1);
    check_burst(2, 4 + DLAT);

    burst(1'b1, 3, NC'(5'b10101), 1'b1);
    chk("t3 in_ready idx4", 32'(lr[4]), 32'd1);
    chk("t3 in_ready idx5", 32'(lr[5]), 32'd0);
    check_burst(3, 5 + DLAT);

    burst(1'b1, 0, '1, 1'b1);
    chk("t4 in_ready idx0", 32'(lr[0]), 32'd0);
    chk("t4 in_ready idx1", 32'(lr[1]), 32'd0);
    chk("t4 busy idx0", 32'(lb[0]), 32'd1);
    check_burst(4, 0);

    // reset during a 6-beat execute, after two beats accepted
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_len = LBW'(6);
    @(negedge clk);
    cmd_valid = 1'b0; in_valid = 1'b1; in_data = beat(0, 1'b1);
    @(negedge clk);
    in_data = beat(1, 1'b1);
    @(negedge clk);
    chk("t5 pre-reset row0 inst", 32'(inst_w[1:0]), 32'd2);
    chk("t5 pre-reset row0 data", 32'(out_w[3:0]), 32'd2);
    in_data = beat(2, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("t5 async out_w", 32'(out_w), 32'd0);
    chk("t5 async inst_w", 32'(inst_w), 32'd0);
    chk("t5 async busy", 32'(busy), 32'd0);
    chk("t5 async done", 32'(done), 32'd0);
    chk("t5 async in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b0; in_data = '0; reset = 1'b1;
    @(negedge clk);
    chk("t5 post cmd_ready", 32'(cmd_ready), 32'd1);
    chk("t5 post busy", 32'(busy), 32'd0);
    chk("t5 post inst_w", 32'(inst_w), 32'd0);
    chk("t5 post out_w", 32'(out_w), 32'd0);

    // fresh load after the aborted burst behaves like the first one
    burst(1'b0, 0, '1, 1'b0);
    check_burst(1, 8 + DLAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
